s3g_tx_arb: RTL and testbench

Shares the single s3g_tx packet transmitter between two packet sources. Requester 0 is the executor response path; requester 1 is an asynchronous event/status reporter. Each requester gets a one-entry holding slot. A round-robin arbiter issues slots to s3g_tx and tracks its busy handshake to completion. It sits between the request sources and s3g_tx; its tx_* outputs drive s3g_tx payload_len, packet_wr and buf0..buf15.

---
 rtl/s3g_pkg.sv | 20 ++
 rtl/s3g_tx_slot.sv | 41 ++++
 rtl/s3g_tx_arb.sv | 122 ++++++++++++
 tb/tb_s3g_tx_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s3g_pkg.sv
// Shared definitions for the s3g transmit path: payload limit, arbiter states
// and the byte-lane packing of the 128-bit packet buffer (byte k at [8k+7:8k]).
package s3g_pkg;

  localparam int MAX_PAYLOAD = 16;
  localparam int BUF_BYTES   = 16;
  localparam int BUF_W       = 8 * BUF_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  function automatic logic [7:0] buf_byte(input logic [BUF_W-1:0] b, input int k);
    return b[8*k +: 8];
  endfunction

endpackage

// File: rtl/s3g_tx_slot.sv
// One-entry holding slot for a packet source: validates and latches len/data.
// Write result (busy or err) visible next cycle; writes while occupied are rejected.
module s3g_tx_slot import s3g_pkg::*; #(
  parameter int MAX_LEN = MAX_PAYLOAD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [7:0]       len,
  input  logic [BUF_W-1:0] data,
  input  logic             free,
  output logic             busy,
  output logic             err,
  output logic [7:0]       slot_len,
  output logic [BUF_W-1:0] slot_data
);

  logic accept;

  assign accept = wr && !busy && (len <= 8'(MAX_LEN));

  // free only arrives while busy, so it can never coincide with accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      err       <= 1'b0;
      slot_len  <= '0;
      slot_data <= '0;
    end else begin
      err <= wr && !accept;
      if (accept) begin
        busy      <= 1'b1;
        slot_len  <= len;
        slot_data <= data;
      end else if (free) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/s3g_tx_arb.sv
// Round-robin arbiter sharing one s3g_tx between two one-entry request slots.
// Load-to-packet_wr 2 cycles; a slot stays busy until tx_busy falls or the busy wait times out.
module s3g_tx_arb #(
  parameter int BUSY_TIMEOUT = 15,
  parameter int MAX_PAYLOAD  = s3g_pkg::MAX_PAYLOAD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_wr,
  input  logic [7:0]   req0_len,
  input  logic [127:0] req0_data,
  output logic         req0_busy,
  output logic         req0_done,
  output logic         req0_err,
  input  logic         req1_wr,
  input  logic [7:0]   req1_len,
  input  logic [127:0] req1_data,
  output logic         req1_busy,
  output logic         req1_done,
  output logic         req1_err,
  input  logic         tx_busy,
  output logic         tx_packet_wr,
  output logic [7:0]   tx_payload_len,
  output logic [127:0] tx_buf,
  output logic         grant_id,
  output logic         timeout
);
  import s3g_pkg::*;

  // The expiry is decided one cycle early so the registered timeout pulse
  // lands BUSY_TIMEOUT cycles after the ISSUE cycle.
  localparam logic [7:0] CNT_LAST = 8'((BUSY_TIMEOUT > 1) ? BUSY_TIMEOUT - 2 : 0);

  arb_state_t   state, state_nxt;
  logic         rr_ptr;
  logic [7:0]   cnt;
  logic         grant, win, finish, expire;
  logic         free0, free1;
  logic [7:0]   len0, len1;
  logic [127:0] data0, data1;

  s3g_tx_slot #(.MAX_LEN(MAX_PAYLOAD)) u_slot0 (
    .clk(clk), .rst(rst), .wr(req0_wr), .len(req0_len), .data(req0_data), .free(free0),
    .busy(req0_busy), .err(req0_err), .slot_len(len0), .slot_data(data0)
  );

  s3g_tx_slot #(.MAX_LEN(MAX_PAYLOAD)) u_slot1 (
    .clk(clk), .rst(rst), .wr(req1_wr), .len(req1_len), .data(req1_data), .free(free1),
    .busy(req1_busy), .err(req1_err), .slot_len(len1), .slot_data(data1)
  );

  assign free0 = finish && !grant_id;
  assign free1 = finish &&  grant_id;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = rr_ptr;
    finish    = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((req0_busy || req1_busy) && !tx_busy) begin
          grant     = 1'b1;
          win       = (req0_busy && req1_busy) ? rr_ptr : req1_busy;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE:  state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (cnt >= CNT_LAST) begin
          finish    = 1'b1;
          expire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      rr_ptr         <= 1'b0;
      cnt            <= '0;
      tx_packet_wr   <= 1'b0;
      tx_payload_len <= '0;
      tx_buf         <= '0;
      grant_id       <= 1'b0;
      timeout        <= 1'b0;
      req0_done      <= 1'b0;
      req1_done      <= 1'b0;
    end else begin
      state        <= state_nxt;
      tx_packet_wr <= grant;
      timeout      <= expire;
      req0_done    <= free0;
      req1_done    <= free1;
      if (state == ST_ISSUE) begin
        cnt <= '0;
      end else if (state == ST_WAIT_BUSY) begin
        cnt <= cnt + 8'd1;
      end
      // tx_* hold the granted packet until the next grant
      if (grant) begin
        tx_payload_len <= win ? len1 : len0;
        tx_buf         <= win ? data1 : data0;
        grant_id       <= win;
        rr_ptr         <= ~win;
      end
    end
  end

endmodule

// File: tb/tb_s3g_tx_arb.sv
// Directed bench for s3g_tx_arb: vector table of write scenarios plus hand-written
// sequences for latency, queued reject, busy timeout, external busy and reset.
module tb_s3g_tx_arb;
  import s3g_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_wr = 1'b0, req1_wr = 1'b0;
  logic [7:0]   req0_len = '0, req1_len = '0;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic         req0_busy, req0_done, req0_err;
  logic         req1_busy, req1_done, req1_err;
  logic         tx_busy, tx_packet_wr, grant_id, timeout;
  logic [7:0]   tx_payload_len;
  logic [127:0] tx_buf;

  logic resp_busy = 1'b0;
  logic man_busy  = 1'b0;
  int   resp_dly  = 1;
  int   resp_hold = 3;
  assign tx_busy = resp_busy | man_busy;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  typedef struct {
    logic [7:0]   len;
    logic [127:0] dat;
    logic         gid;
    int           cyc;
  } pkt_t;
  pkt_t pkt_q[$];

  int done0_n = 0, done1_n = 0, to_n = 0;
  int done0_cyc = 0;

  typedef struct {
    bit         w0;
    logic [7:0] l0;
    bit         w1;
    logic [7:0] l1;
    bit         e0;
    bit         e1;
    int         npk;
    bit         first;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  s3g_tx_arb #(.BUSY_TIMEOUT(15), .MAX_PAYLOAD(16)) dut (
    .clk(clk), .rst(rst),
    .req0_wr(req0_wr), .req0_len(req0_len), .req0_data(req0_data),
    .req0_busy(req0_busy), .req0_done(req0_done), .req0_err(req0_err),
    .req1_wr(req1_wr), .req1_len(req1_len), .req1_data(req1_data),
    .req1_busy(req1_busy), .req1_done(req1_done), .req1_err(req1_err),
    .tx_busy(tx_busy), .tx_packet_wr(tx_packet_wr), .tx_payload_len(tx_payload_len),
    .tx_buf(tx_buf), .grant_id(grant_id), .timeout(timeout)
  );

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // s3g_tx stand-in: raise busy resp_dly cycles after packet_wr, hold resp_hold cycles
  always begin
    @(negedge clk);
    if (tx_packet_wr && resp_dly != 0) begin
      repeat (resp_dly) @(negedge clk);
      resp_busy = 1'b1;
      repeat (resp_hold) @(negedge clk);
      resp_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_packet_wr) pkt_q.push_back('{tx_payload_len, tx_buf, grant_id, cyc_n});
    if (req0_done) begin done0_n++; done0_cyc = cyc_n; end
    if (req1_done) done1_n++;
    if (timeout) to_n++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] outs();
    return {15'b0, req0_busy, req0_done, req0_err, req1_busy, req1_done, req1_err,
            tx_packet_wr, tx_payload_len, tx_buf, grant_id, timeout};
  endfunction

  function automatic bit cond(input int sel, input int arg);
    case (sel)
      0:       return pkt_q.size() >= arg;
      1:       return !req0_busy && !req1_busy;
      default: return done0_n >= arg;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int arg, input int max_cyc, input string name);
    int n = 0;
    bit hit;
    hit = cond(sel, arg);
    while (!hit && n < max_cyc) begin
      cyc();
      n++;
      hit = cond(sel, arg);
    end
    chk(name, 160'(hit), 160'(1));
  endtask

  function automatic vec_t mk(bit w0, int l0, bit w1, int l1, bit e0, bit e1, int npk, bit first);
    vec_t v;
    v.w0 = w0; v.l0 = 8'(l0); v.w1 = w1; v.l1 = 8'(l1);
    v.e0 = e0; v.e1 = e1; v.npk = npk; v.first = first;
    return v;
  endfunction

  initial begin
    int L, I, R, d0b, d1b, tob;
    logic [127:0] d0, d1;
    logic g;

    // rr_ptr walk: 0 ->(0,1) 0 ->(0) 1 ->(1,0) 1 -> 1 ->(1) 0 ->(0) 1 ->(1,0) 1
    tbl[0] = mk(1, 2,   1, 4,  0, 0, 2, 0);
    tbl[1] = mk(1, 0,   0, 0,  0, 0, 1, 0);
    tbl[2] = mk(1, 5,   1, 16, 0, 0, 2, 1);
    tbl[3] = mk(0, 0,   1, 17, 0, 1, 0, 0);
    tbl[4] = mk(1, 200, 1, 1,  1, 0, 1, 1);
    tbl[5] = mk(1, 16,  1, 17, 0, 1, 1, 0);
    tbl[6] = mk(1, 1,   1, 7,  0, 0, 2, 1);

    cyc();
    cyc();
    chk("reset outputs", outs(), '0);
    rst = 1'b1;
    cyc();
    chk("idle after reset", outs(), '0);

    for (int i = 0; i < 7; i++) begin
      d0 = {4{32'hA0A0_0000 | 32'(i)}};
      d1 = {4{32'hB1B1_0000 | 32'(i)}};
      pkt_q.delete();
      d0b = done0_n;
      d1b = done1_n;
      req0_wr = tbl[i].w0; req0_len = tbl[i].l0; req0_data = d0;
      req1_wr = tbl[i].w1; req1_len = tbl[i].l1; req1_data = d1;
      cyc();
      req0_wr = 1'b0;
      req1_wr = 1'b0;
      chk($sformatf("v%0d busy", i), 160'({req0_busy, req1_busy}),
          160'({tbl[i].w0 && !tbl[i].e0, tbl[i].w1 && !tbl[i].e1}));
      chk($sformatf("v%0d err", i), 160'({req0_err, req1_err}), 160'({tbl[i].e0, tbl[i].e1}));
      wait_for(1, 0, 80, $sformatf("v%0d drain", i));
      repeat (3) cyc();
      chk($sformatf("v%0d pkt count", i), 160'(pkt_q.size()), 160'(tbl[i].npk));
      chk($sformatf("v%0d done pulses", i), 160'({done0_n - d0b, done1_n - d1b}),
          160'({32'(tbl[i].w0 && !tbl[i].e0), 32'(tbl[i].w1 && !tbl[i].e1)}));
      for (int k = 0; k < tbl[i].npk && k < pkt_q.size(); k++) begin
        g = (k == 0) ? tbl[i].first : !tbl[i].first;
        chk($sformatf("v%0d p%0d gid", i, k), 160'(pkt_q[k].gid), 160'(g));
        chk($sformatf("v%0d p%0d len", i, k), 160'(pkt_q[k].len), 160'(g ? tbl[i].l1 : tbl[i].l0));
        chk($sformatf("v%0d p%0d data", i, k), 160'(pkt_q[k].dat), 160'(g ? d1 : d0));
      end
    end

    // exact latency: busy rises 1 cycle after packet_wr and is held 20 cycles
    resp_dly = 1;
    resp_hold = 20;
    pkt_q.delete();
    d0b = done0_n;
    L = cyc_n;
    req0_wr = 1'b1; req0_len = 8'd3; req0_data = 128'h030201;
    cyc();
    req0_wr = 1'b0;
    wait_for(2, d0b + 1, 40, "lat done wait");
    chk("lat pkt count", 160'(pkt_q.size()), 160'(1));
    if (pkt_q.size() > 0) begin
      chk("lat packet_wr cycle", 160'(pkt_q[0].cyc), 160'(L + 2));
      chk("lat len", 160'(pkt_q[0].len), 160'(3));
      chk("lat bytes", 160'({buf_byte(pkt_q[0].dat, 2), buf_byte(pkt_q[0].dat, 1),
                             buf_byte(pkt_q[0].dat, 0)}), 160'(24'h030201));
      chk("lat gid", 160'(pkt_q[0].gid), 160'(0));
    end
    chk("lat done cycle", 160'(done0_cyc), 160'(L + 24));
    chk("lat busy at done", 160'(req0_busy), 160'(0));
    chk("lat len held", 160'(tx_payload_len), 160'(3));

    // reject a write to slot 0 while it is queued behind a slot 1 transfer
    resp_hold = 10;
    pkt_q.delete();
    req1_wr = 1'b1; req1_len = 8'd2; req1_data = 128'h1111;
    cyc();
    req1_wr = 1'b0;
    wait_for(0, 1, 10, "rej first issue");
    req0_wr = 1'b1; req0_len = 8'd3; req0_data = 128'hAAAA;
    cyc();
    req0_len = 8'd5; req0_data = 128'hBBBB;
    cyc();
    req0_wr = 1'b0;
    chk("rej err/busy", 160'({req0_err, req0_busy}), 160'(2'b11));
    wait_for(1, 0, 80, "rej drain");
    chk("rej pkt count", 160'(pkt_q.size()), 160'(2));
    if (pkt_q.size() > 1) begin
      chk("rej order", 160'({pkt_q[0].gid, pkt_q[1].gid}), 160'(2'b10));
      chk("rej kept len", 160'(pkt_q[1].len), 160'(3));
      chk("rej kept data", 160'(pkt_q[1].dat), 160'(128'hAAAA));
    end

    // tx_busy never rises: timeout after 15 cycles, queued slot 1 follows
    resp_dly = 0;
    pkt_q.delete();
    tob = to_n;
    req0_wr = 1'b1; req0_len = 8'd4; req0_data = 128'hC0C0;
    cyc();
    req0_wr = 1'b0;
    req1_wr = 1'b1; req1_len = 8'd6; req1_data = 128'hD0D0;
    cyc();
    req1_wr = 1'b0;
    I = cyc_n;
    chk("to issue", 160'({tx_packet_wr, grant_id}), 160'(2'b10));
    repeat (14) cyc();
    chk("to not early", 160'({timeout, req0_done, req0_busy}), 160'(3'b001));
    cyc();
    chk("to pulse", 160'({timeout, req0_done, req0_busy}), 160'(3'b110));
    chk("to cycle", 160'(cyc_n), 160'(I + 15));
    resp_dly = 1;
    resp_hold = 2;
    wait_for(1, 0, 40, "to drain");
    chk("to pkt count", 160'(pkt_q.size()), 160'(2));
    if (pkt_q.size() > 1) begin
      chk("to next gid", 160'(pkt_q[1].gid), 160'(1));
      chk("to next data", 160'({pkt_q[1].len, pkt_q[1].dat}), 160'({8'd6, 128'hD0D0}));
    end
    chk("to count", 160'(to_n - tob), 160'(1));

    // external sender holds tx_busy in IDLE
    man_busy = 1'b1;
    pkt_q.delete();
    req0_wr = 1'b1; req0_len = 8'd1; req0_data = 128'h77;
    cyc();
    req0_wr = 1'b0;
    repeat (5) cyc();
    chk("ext busy holds", 160'(pkt_q.size()), 160'(0));
    man_busy = 1'b0;
    R = cyc_n;
    wait_for(0, 1, 10, "ext release");
    if (pkt_q.size() > 0) chk("ext issue cycle", 160'(pkt_q[0].cyc), 160'(R + 1));
    wait_for(1, 0, 40, "ext drain");

    // reset during WAIT_DONE with both slots full
    resp_dly = 0;
    pkt_q.delete();
    req0_wr = 1'b1; req0_len = 8'd2; req0_data = 128'h22;
    req1_wr = 1'b1; req1_len = 8'd3; req1_data = 128'h33;
    cyc();
    req0_wr = 1'b0;
    req1_wr = 1'b0;
    wait_for(0, 1, 10, "rst first issue");
    man_busy = 1'b1;
    repeat (3) cyc();
    chk("rst both queued", 160'({req0_busy, req1_busy}), 160'(2'b11));
    rst = 1'b0;
    #1;
    chk("rst async clear", outs(), '0);
    man_busy = 1'b0;
    cyc();
    cyc();
    pkt_q.delete();
    rst = 1'b1;
    repeat (20) cyc();
    chk("rst no issue", 160'(pkt_q.size()), 160'(0));
    chk("rst slots empty", 160'({req0_busy, req1_busy}), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
